program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 37 +++
 rtl/loader_word_assembler.sv | 47 ++++
 rtl/program_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants for the program loader
//
// Purpose: FSM state encoding, header width and word geometry shared by
//          program_loader and loader_word_assembler.
// Ports:   none (package).

package loader_pkg;

  // Header carries a 16-bit word count, sent most significant byte first.
  localparam int HDR_WIDTH      = 16;

  // Each instruction word arrives as 4 bytes, most significant byte first.
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int WORD_BITS      = BYTES_PER_WORD * 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR_HI  = 3'd1;
  localparam logic [2:0] S_HDR_LO  = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  // A new load may only begin from a resting state.
  function automatic logic is_resting(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

  // States in which a load is in progress.
  function automatic logic is_busy(input state_t s);
    return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_COLLECT) || (s == S_WRITE);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - byte-to-word shift register with byte counter
//
// Purpose: shifts accepted bytes into a word, MSB first, and flags the byte
//          that completes a word.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   clear           - synchronous clear of the shift register and byte counter
//   shift_en        - a byte is accepted this cycle
//   byte_data       - the accepted byte
//   assembled       - the word as it will be once byte_data is shifted in
//   last_byte       - shift_en on the final byte of a word

module loader_word_assembler
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [7:0]           byte_data,
  output logic [WORD_BITS-1:0] assembled,
  output logic                 last_byte
);

  logic [WORD_BITS-1:0]  shift_q;
  logic [BYTE_CNT_W-1:0] byte_count;

  // Exposing the post-shift value lets the FSM capture a complete word on
  // the same edge that accepts its last byte.
  assign assembled = {shift_q[WORD_BITS-9:0], byte_data};
  assign last_byte = shift_en && (byte_count == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      byte_count <= '0;
    end else if (clear) begin
      shift_q    <= '0;
      byte_count <= '0;
    end else if (shift_en) begin
      shift_q    <= assembled;
      // Counter width matches bytes-per-word, so it wraps 3 -> 0 naturally.
      byte_count <= byte_count + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader writing words to memory
//
// Purpose: reads a 16-bit word count header followed by count 4-byte words
//          from a byte stream and writes each word to program memory at
//          consecutive word addresses starting at BASE_ADDRESS.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   start               - one-cycle load request (ignored while busy)
//   abort               - synchronous return to idle, highest priority
//   byte_valid/data     - incoming byte stream
//   byte_ready          - loader accepts a byte this cycle
//   mem_write           - program-memory write strobe
//   mem_address         - byte address of the write
//   mem_write_data      - instruction word
//   busy, done, error   - load in progress / completed / header rejected

module program_loader
  import loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_t               state;
  logic [7:0]           hdr_hi;
  logic [HDR_WIDTH-1:0] word_count;
  logic [HDR_WIDTH-1:0] word_index;
  logic [HDR_WIDTH-1:0] next_index;
  logic [HDR_WIDTH-1:0] hdr_count;

  logic                 accept;
  logic                 start_ok;
  logic                 asm_clear;
  logic                 asm_shift;
  logic                 asm_last;
  logic [WORD_BITS-1:0] asm_word;

  // Handshake outputs are pure functions of state, never of byte_valid.
  assign byte_ready = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_COLLECT);
  assign mem_write  = (state == S_WRITE);
  assign busy       = is_busy(state);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);

  assign accept     = byte_ready && byte_valid;
  assign start_ok   = start && is_resting(state);
  assign hdr_count  = {hdr_hi, byte_data};
  assign next_index = word_index + 1'b1;

  // Abort drops any partially shifted word so it can never be written.
  assign asm_clear  = abort || start_ok;
  assign asm_shift  = accept && (state == S_COLLECT);

  loader_word_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_data (byte_data),
    .assembled (asm_word),
    .last_byte (asm_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      hdr_hi         <= '0;
      word_count     <= '0;
      word_index     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_HDR_HI;
            hdr_hi     <= '0;
            word_count <= '0;
            word_index <= '0;
          end
        end

        S_HDR_HI: begin
          if (accept) begin
            hdr_hi <= byte_data;
            state  <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          if (accept) begin
            word_count <= hdr_count;
            if ((hdr_count == '0) || (int'(hdr_count) > MEMORY_DEPTH)) begin
              state <= S_ERROR;
            end else begin
              state <= S_COLLECT;
            end
          end
        end

        S_COLLECT: begin
          // Address and data are registered here and held until the next
          // word, so they stay stable whenever mem_write is low.
          if (asm_last) begin
            mem_write_data <= DATA_WIDTH'(asm_word);
            mem_address    <= BASE_ADDRESS
                              + DATA_WIDTH'(word_index) * DATA_WIDTH'(BYTES_PER_WORD);
            state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          word_index <= next_index;
          if (next_index == word_count) begin
            state <= S_DONE;
          end else begin
            state <= S_COLLECT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
